// File: rtl/sap_datapath_if.sv
// sap_datapath_if
//   Groups the control word, programming port and observation outputs of the
//   SAP datapath into one bundle.
//   master : sequencer / programmer side (drives control + prog, reads outputs)
//   slave  : datapath side (reads control + prog, drives outputs)
//   Signals:
//     hlt mi ri ro io ii ai ao sumo sub bi oi ce co j : control word
//     prog_mode prog_we prog_addr prog_data          : RAM programming port
//     insn bus pc out_val out_valid carry zero        : datapath outputs
//   Optional: BUS_CHECK_EN adds bus_err (sticky multi-driver flag).
interface sap_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j;
    logic              prog_mode;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] insn;
    logic [DATA_W-1:0] bus;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] out_val;
    logic              out_valid;
    logic              carry;
    logic              zero;
`ifdef BUS_CHECK_EN
    logic              bus_err;
`endif

    modport master (
`ifdef BUS_CHECK_EN
        input  bus_err,
`endif
        output hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j,
        output prog_mode, prog_we, prog_addr, prog_data,
        input  insn, bus, pc, out_val, out_valid, carry, zero
    );

    modport slave (
`ifdef BUS_CHECK_EN
        output bus_err,
`endif
        input  hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j,
        input  prog_mode, prog_we, prog_addr, prog_data,
        output insn, bus, pc, out_val, out_valid, carry, zero
    );
endinterface

// File: rtl/sap_datapath.sv
// sap_datapath
//   Register/bus datapath of the 8-bit SAP CPU: PC, MAR, 16x8 RAM, IR, A, B,
//   ALU, OUT register and the shared bus. Executes the control word presented
//   by the sequencer and returns IR contents as insn.
//   Ports:
//     clk : clock, all state updates on posedge
//     rst : asynchronous active-high reset (RAM contents are preserved)
//     dp  : sap_datapath_if.slave (control word, prog port, observation outputs)
//   Optional feature macro: BUS_CHECK_EN -> dp.bus_err, sticky flag set when
//   more than one bus driver is enabled on an unhalted edge.
module sap_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    sap_datapath_if.slave dp
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] a_q,   a_d;
    logic [DATA_W-1:0] b_q,   b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] bus;

    // Subtraction as two's complement in 9 bits so carry means "no borrow".
    always_comb begin
        alu_sum = {1'b0, a_q} + (dp.sub ? ({1'b0, ~b_q} + (DATA_W+1)'(1))
                                        : {1'b0, b_q});
    end

    always_comb begin
        bus = '0;
        if (dp.co)        bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        else if (dp.ro)   bus = ram_q[mar_q];
        else if (dp.io)   bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
        else if (dp.ao)   bus = a_q;
        else if (dp.sumo) bus = alu_sum[DATA_W-1:0];
    end

    // Loads sample the pre-edge bus, so a register driving and loading the
    // bus in the same cycle keeps its old value.
    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (!dp.hlt) begin
            if (dp.mi) mar_d = bus[ADDR_W-1:0];
            if (dp.ii) ir_d  = bus;
            if (dp.ai) a_d   = bus;
            if (dp.bi) b_d   = bus;
            if (dp.oi) out_d = bus;
            if (dp.j)       pc_d = bus[ADDR_W-1:0];
            else if (dp.ce) pc_d = pc_q + ADDR_W'(1);
            out_valid_d = dp.oi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // RAM has no reset so the loaded program survives rst.
    always_ff @(posedge clk) begin
        if (dp.prog_mode) begin
            if (dp.prog_we) ram_q[dp.prog_addr] <= dp.prog_data;
        end else if (!dp.hlt && dp.ri) begin
            ram_q[mar_q] <= bus;
        end
    end

`ifdef BUS_CHECK_EN
    logic [2:0] n_drv;
    logic       bus_err_q, bus_err_d;

    always_comb begin
        n_drv = 3'(dp.co) + 3'(dp.ro) + 3'(dp.io) + 3'(dp.ao) + 3'(dp.sumo);
        bus_err_d = bus_err_q | (!dp.hlt && (n_drv > 3'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus_err_q <= 1'b0;
        else     bus_err_q <= bus_err_d;
    end

    assign dp.bus_err = bus_err_q;
`endif

    assign dp.insn      = ir_q;
    assign dp.bus       = bus;
    assign dp.pc        = pc_q;
    assign dp.out_val   = out_q;
    assign dp.out_valid = out_valid_q;
    assign dp.carry     = alu_sum[DATA_W];
    assign dp.zero      = (alu_sum[DATA_W-1:0] == '0);
endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath
//   Directed scenarios plus randomized control words for sap_datapath,
//   checked against a behavioural model of the SAP register/bus rules.
module tb_sap_datapath;
    localparam int DW = 8;
    localparam int AW = 4;

    typedef logic [14:0] cw_t;
    localparam cw_t HLT  = 15'h0001;
    localparam cw_t MI   = 15'h0002;
    localparam cw_t RI   = 15'h0004;
    localparam cw_t RO   = 15'h0008;
    localparam cw_t IO   = 15'h0010;
    localparam cw_t II   = 15'h0020;
    localparam cw_t AI   = 15'h0040;
    localparam cw_t AO   = 15'h0080;
    localparam cw_t SUMO = 15'h0100;
    localparam cw_t SUB  = 15'h0200;
    localparam cw_t BI   = 15'h0400;
    localparam cw_t OI   = 15'h0800;
    localparam cw_t CE   = 15'h1000;
    localparam cw_t CO   = 15'h2000;
    localparam cw_t J    = 15'h4000;
    localparam cw_t DRV  = CO | RO | IO | AO | SUMO;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sap_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) dif ();

    sap_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dif)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference state
    int unsigned m_pc, m_mar, m_ir, m_a, m_b, m_out, m_ov, m_err;
    int unsigned m_ram [16];

    // Values seen just before the last edge of cycle()
    logic [7:0] obs_bus;
    logic       obs_carry, obs_zero;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit has(input cw_t cw, input cw_t m);
        return (cw & m) != '0;
    endfunction

    function automatic int unsigned ref_sum(input cw_t cw);
        return m_a + (has(cw, SUB) ? (256 - m_b) : m_b);
    endfunction

    function automatic int unsigned ref_bus(input cw_t cw);
        if (has(cw, CO))   return m_pc;
        if (has(cw, RO))   return m_ram[m_mar];
        if (has(cw, IO))   return m_ir % 16;
        if (has(cw, AO))   return m_a;
        if (has(cw, SUMO)) return ref_sum(cw) % 256;
        return 0;
    endfunction

    task automatic drive(input cw_t cw, input bit pm, input bit pwe,
                         input int unsigned pa, input int unsigned pd);
        dif.hlt  = cw[0];  dif.mi = cw[1];  dif.ri   = cw[2];  dif.ro = cw[3];
        dif.io   = cw[4];  dif.ii = cw[5];  dif.ai   = cw[6];  dif.ao = cw[7];
        dif.sumo = cw[8];  dif.sub = cw[9]; dif.bi   = cw[10]; dif.oi = cw[11];
        dif.ce   = cw[12]; dif.co = cw[13]; dif.j    = cw[14];
        dif.prog_mode = pm;
        dif.prog_we   = pwe;
        dif.prog_addr = AW'(pa);
        dif.prog_data = DW'(pd);
    endtask

    task automatic check_regs(input string ph);
        check({ph, "_pc"},        dif.pc,        m_pc);
        check({ph, "_insn"},      dif.insn,      m_ir);
        check({ph, "_out_val"},   dif.out_val,   m_out);
        check({ph, "_out_valid"}, dif.out_valid, m_ov);
`ifdef BUS_CHECK_EN
        check({ph, "_bus_err"},   dif.bus_err,   m_err);
`endif
    endtask

    task automatic cycle(input cw_t cw, input bit pm, input bit pwe,
                         input int unsigned pa, input int unsigned pd);
        int unsigned be, s;
        @(negedge clk);
        drive(cw, pm, pwe, pa, pd);
        #1;
        be = ref_bus(cw);
        s  = ref_sum(cw);
        obs_bus   = dif.bus;
        obs_carry = dif.carry;
        obs_zero  = dif.zero;
        check("bus",   dif.bus,   be);
        check("carry", dif.carry, (s >> 8) & 1);
        check("zero",  dif.zero,  (s % 256) == 0);
        check_regs("pre");
        if (!has(cw, HLT)) begin
            if (has(cw, RI) && !pm) m_ram[m_mar] = be;
            if (has(cw, MI)) m_mar = be % 16;
            if (has(cw, II)) m_ir  = be;
            if (has(cw, AI)) m_a   = be;
            if (has(cw, BI)) m_b   = be;
            if (has(cw, OI)) m_out = be;
            if (has(cw, J))       m_pc = be % 16;
            else if (has(cw, CE)) m_pc = (m_pc + 1) % 16;
            m_ov = has(cw, OI);
            if ($countones(cw & DRV) > 1) m_err = 1;
        end else begin
            m_ov = 0;
        end
        if (pm && pwe) m_ram[pa % 16] = pd % 256;
        @(posedge clk);
        #1;
        check_regs("post");
    endtask

    task automatic cyc(input cw_t cw);
        cycle(cw, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic prog(input int unsigned pa, input int unsigned pd);
        cycle('0, 1'b1, 1'b1, pa, pd);
    endtask

    // Put val on the bus via RAM at the current PC and load it into dest.
    task automatic load(input cw_t dest, input int unsigned val);
        prog(m_pc, val);
        cyc(MI | CO);
        cyc(RO | dest);
    endtask

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
        m_out = 0; m_ov = 0; m_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive('0, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_bus",   dif.bus,   8'h00);
        check("rst_carry", dif.carry, 1'b0);
        check("rst_zero",  dif.zero,  1'b1);
        check_regs("rst");
        #2;
        rst = 1'b0;
    endtask

    initial begin
        cw_t         rcw;
        bit          rpm, rpwe;
        int unsigned rpa, rpd;

        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Fill RAM so every location has a known value
        for (int i = 0; i < 16; i++) prog(i, $urandom_range(0, 255));

        // Program + LDA fetch/execute
        prog(0, 8'h1E);
        prog(14, 8'h2A);
        do_reset();
        cyc(MI | CO);
        cyc(RO | II | CE);
        check("lda_insn", dif.insn, 8'h1E);
        check("lda_pc",   dif.pc,   4'd1);
        cyc(MI | IO);
        cyc(RO | AI);
        cyc(AO);
        check("lda_a", obs_bus, 8'h2A);

        // Async reset mid-run clears A before any edge
        load(AI, 8'h42);
        @(negedge clk);
        drive(AO, 1'b0, 1'b0, 0, 0);
        #1;
        check("pre_rst_a", dif.bus, 8'h42);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_a", dif.bus, 8'h00);
        check_regs("rst_async");
        #1 rst = 1'b0;

        // ADD
        load(AI, 8'h05);
        load(BI, 8'h07);
        cyc(SUMO | AI);
        check("add_bus",   obs_bus,   8'h0C);
        check("add_carry", obs_carry, 1'b0);
        cyc(AO);
        check("add_a", obs_bus, 8'h0C);
        load(AI, 8'hFF);
        load(BI, 8'h01);
        cyc(SUMO);
        check("addw_bus",   obs_bus,   8'h00);
        check("addw_carry", obs_carry, 1'b1);
        check("addw_zero",  obs_zero,  1'b1);

        // SUB
        load(AI, 8'h05);
        load(BI, 8'h07);
        cyc(SUMO | SUB);
        check("sub_neg_bus",   obs_bus,   8'hFE);
        check("sub_neg_carry", obs_carry, 1'b0);
        load(AI, 8'h07);
        load(BI, 8'h05);
        cyc(SUMO | SUB);
        check("sub_pos_bus",   obs_bus,   8'h02);
        check("sub_pos_carry", obs_carry, 1'b1);

        // PC wrap, jump priority, OUT
        load(J, 15);
        check("pc_15", dif.pc, 4'd15);
        cyc(CE);
        check("pc_wrap", dif.pc, 4'd0);
        load(II, 8'h63);
        cyc(IO | J | CE);
        check("jmp_pc", dif.pc, 4'd3);
        load(AI, 8'h99);
        cyc(AO | OI);
        check("out_val",   dif.out_val,   8'h99);
        check("out_valid", dif.out_valid, 1'b1);
        cyc('0);
        check("out_valid_drop", dif.out_valid, 1'b0);

        // Halt and programming interplay
        load(AI, 8'h55);
        load(BI, 8'h11);
        cyc(HLT | AO | BI);
        cyc(SUMO);
        check("hlt_b_kept", obs_bus, 8'h66);
        load(J, 8);
        cycle(HLT, 1'b1, 1'b1, 3, 8'hA5);
        load(MI, 3);
        cyc(RO);
        check("prog_hlt", obs_bus, 8'hA5);
        cycle(AO | RI, 1'b1, 1'b0, 0, 0);
        cyc(RO);
        check("ri_prog_blocked", obs_bus, 8'hA5);

`ifdef BUS_CHECK_EN
        check("bus_err_clear", dif.bus_err, 1'b0);
        cyc(CO | AO);
        check("bus_err_prio", obs_bus, 8'h08);
        check("bus_err_set",  dif.bus_err, 1'b1);
        cyc('0);
        check("bus_err_sticky", dif.bus_err, 1'b1);
        do_reset();
        check("bus_err_rst", dif.bus_err, 1'b0);
`endif

        // Randomized control words
        for (int n = 0; n < 400; n++) begin
            rcw = cw_t'($urandom & $urandom) & ~HLT;
            if ($urandom_range(0, 7) == 0) rcw = rcw | HLT;
            rpm  = ($urandom_range(0, 7) == 0);
            rpwe = $urandom_range(0, 1) == 1;
            rpa  = $urandom_range(0, 15);
            rpd  = $urandom_range(0, 255);
            cycle(rcw, rpm, rpwe, rpa, rpd);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
Register/bus datapath of the 8-bit SAP CPU. It executes the control word that the microcode sequencer drives on the negative clock edge, and it returns the instruction register to that sequencer. Contents: PC, MAR, 16x8 RAM, IR, A, B, ALU, OUT register and the shared 8-bit bus. It also includes a direct RAM programming port, used while prog_mode is high.

Parameters:
DATA_W, 8, bus/register width (only 8 supported)
ADDR_W, 4, PC/MAR/RAM address width; RAM depth = 2**ADDR_W

Ports:
Clock and reset (already decided): one clock, clk; reset rst, asynchronous, active-high.
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j  in  1 each  control word from sequencer
prog_mode  in  1  programming mode
prog_we  in  1  RAM program write strobe
prog_addr  in  ADDR_W  RAM program address
prog_data  in  DATA_W  RAM program data
insn  out  DATA_W  IR contents to sequencer
bus  out  DATA_W  current bus value (observation)
pc  out  ADDR_W  program counter
out_val  out  DATA_W  OUT register
out_valid  out  1  one-cycle pulse after an OUT load
carry  out  1  ALU carry, combinational
zero  out  1  ALU result == 0, combinational

Behaviour:
- Bus mux (combinational):
  - co -> {0, pc}
  - ro -> ram[mar]
  - io -> {0, ir[3:0]}
  - ao -> a
  - sumo -> alu_sum[7:0]
  - none -> 8'h00
- Bus priority when several enables are active: co > ro > io > ao > sumo.
- ALU (9-bit): alu_sum = a + (sub ? (~b + 1) : b).
  - carry = alu_sum[8].
  - zero = (alu_sum[7:0] == 0).
- On posedge clk, with rst low and hlt low, every active load samples the bus:
  - mi: mar <= bus[3:0]
  - ii: ir <= bus
  - ai: a <= bus
  - bi: b <= bus
  - oi: out_val <= bus
  - ri: ram[mar] <= bus, only when prog_mode = 0
  - j: pc <= bus[3:0]
  - ce without j: pc <= pc + 1, wrapping 15 -> 0
- Register conflicts:
  - j and ce together: j wins.
  - A register that is both driving and loading the bus captures its own old value (read-before-write); ai+ao leaves A unchanged.
  - sumo+ai loads A with a + b (or a - b when sub) computed from the pre-edge values.
- out_valid is 1 for exactly the cycle after an oi load, otherwise 0. It is not asserted while hlt is high.
- hlt high suppresses all control-driven register and RAM writes. Combinational outputs keep tracking.
- Programming path: prog_mode = 1 and prog_we = 1 -> ram[prog_addr] <= prog_data on posedge. This is independent of hlt. Control-driven ri is ignored while prog_mode = 1.
- insn = ir, registered; no added latency.
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - pc, mar, ir, a, b, out_val <= 0; out_valid <= 0.
  - RAM is NOT cleared; the loaded program survives reset.
  - After reset, with no enables active: bus = 8'h00 and carry = 0. zero = 1, since a = b = 0 gives sum 0.

Optional Feature:
BUS_CHECK_EN
- Defined:
  - Adds output port bus_err (1 bit), a registered sticky flag, cleared only by rst.
  - bus_err sets on any posedge where more than one of {co, ro, io, ao, sumo} is high and hlt is low.
  - The bus value still follows the fixed priority.
- Undefined: no bus_err port. Multiple enables are resolved silently by priority.

Test Plan:
1. Reset: after rst pulse, pc=0, insn=0, out_val=0, out_valid=0; bus=00, carry=0, zero=1 with no enables. Assert rst mid-run with a=0x42 -> a=0 immediately, before any clock edge.
2. Program + LDA fetch/execute:
   - Load program via prog port: ram[0]=0x1E, ram[14]=0x2A.
   - Drive mi+co -> mar=0.
   - Drive ro+ii+ce -> insn=0x1E, pc=1.
   - Drive mi+io -> mar=0xE.
   - Drive ro+ai -> a=0x2A.
3. ADD: a=0x05, b=0x07, sumo+ai -> a=0x0C, carry=0. Then a=0xFF, b=0x01: bus=00, carry=1, zero=1.
4. SUB: a=0x05, b=0x07, sub=1 -> bus=0xFE, carry=0. a=0x07, b=0x05, sub=1 -> bus=0x02, carry=1.
5. PC and OUT:
   - pc=15, ce -> pc=0.
   - io with ir=0x63, j+ce -> pc=3.
   - ao+oi with a=0x99 -> out_val=0x99, out_valid high one cycle.
6. Halt/program interplay:
   - hlt=1 with ao+bi (a=0x55) -> b unchanged.
   - prog_mode=1, prog_we=1, addr 3, data 0xA5 during hlt -> ram[3]=0xA5.
   - ri with prog_mode=1 -> no control-driven write.
   - With BUS_CHECK_EN: co+ao together -> bus=pc value, bus_err=1 sticky until rst.
